// File: rtl/clu_slice_sequencer_pkg.sv
// Shared types and constants for the slice-serial carry-lookahead add/subtract engine.
package clu_slice_sequencer_pkg;

  // Bits handled per lookahead-unit pass.
  localparam int unsigned SliceW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Slice counter width; kept at least one bit so a single-slice build still has a counter.
  function automatic int unsigned cnt_width(input int unsigned nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/clu_slice_sequencer_if.sv
// Operand/result handshake plus the slice bus towards the 4-bit domino lookahead unit.
interface clu_slice_sequencer_if
  import clu_slice_sequencer_pkg::*;
#(
  parameter int unsigned Width = 16
);

  logic              start;
  logic              sub;
  logic [Width-1:0]  a;
  logic [Width-1:0]  b;
  logic              busy;
  logic              done;
  logic [Width-1:0]  sum;
  logic              cout;
  logic              ovf;
  logic [SliceW-1:0] clu_p;
  logic [SliceW-1:0] clu_g;
  logic              clu_c0;
  logic [SliceW-1:0] clu_c;  // C4..C1

  // Controller and carry unit side.
  modport master (
    output start, sub, a, b, clu_c,
    input  busy, done, sum, cout, ovf, clu_p, clu_g, clu_c0
  );

  // Sequencer side.
  modport slave (
    input  start, sub, a, b, clu_c,
    output busy, done, sum, cout, ovf, clu_p, clu_g, clu_c0
  );

endinterface

// File: rtl/clu_slice_sequencer_pg_slice.sv
// Propagate/generate for one 4-bit slice and the sum bits from the returned carries.
module pg_slice
  import clu_slice_sequencer_pkg::*;
(
  input  logic [SliceW-1:0] a,
  input  logic [SliceW-1:0] b,
  input  logic              c0,
  input  logic [SliceW-2:0] c_hi,  // C3..C1
  output logic [SliceW-1:0] p,
  output logic [SliceW-1:0] g,
  output logic [SliceW-1:0] s
);

  // Bitwise P/G and sum formation; carries come from the lookahead unit.
  always_comb begin
    p = a ^ b;
    g = a & b;
    s = p ^ {c_hi, c0};
  end

endmodule

// File: rtl/clu_slice_sequencer.sv
// Slice-serial add/subtract: feeds one 4-bit slice per PHI cycle through a shared domino
// carry-lookahead unit and chains C4 into the next slice. All state moves on falling PHI.
module clu_slice_sequencer
  import clu_slice_sequencer_pkg::*;
#(
  parameter int unsigned Width = 16  // multiple of 4, at least 4
) (
  input  logic                phi,
  input  logic                rst_,
  clu_slice_sequencer_if.slave bus
);

  localparam int unsigned NSlice = Width / SliceW;
  localparam int unsigned CntW   = cnt_width(NSlice);
  localparam logic [CntW-1:0] LastCnt = CntW'(NSlice - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [Width-1:0] a_q, a_d;
  logic [Width-1:0] beff_q, beff_d;
  logic [Width-1:0] psum_q, psum_d;
  logic [Width-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  int unsigned       base;
  logic [SliceW-1:0] slice_a, slice_b;
  logic [SliceW-1:0] slice_p, slice_g, slice_s;

  // Select the operand slice currently in flight.
  always_comb begin
    base    = SliceW * 32'(cnt_q);
    slice_a = a_q[base +: SliceW];
    slice_b = beff_q[base +: SliceW];
  end

  pg_slice u_pg_slice (
    .a    (slice_a),
    .b    (slice_b),
    .c0   (carry_q),
    .c_hi (bus.clu_c[SliceW-2:0]),
    .p    (slice_p),
    .g    (slice_g),
    .s    (slice_s)
  );

  // Slice bus is driven only from registers, so it holds steady through precharge and evaluate.
  always_comb begin
    bus.clu_p  = (state_q == StRun) ? slice_p : '0;
    bus.clu_g  = (state_q == StRun) ? slice_g : '0;
    bus.clu_c0 = (state_q == StRun) ? carry_q : 1'b0;
    bus.busy   = (state_q == StRun);
    bus.done   = (state_q == StDone);
    bus.sum    = sum_q;
    bus.cout   = cout_q;
    bus.ovf    = ovf_q;
  end

  // Next-state: accept in IDLE/DONE, capture carries and advance in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    beff_d  = beff_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = bus.a;
          beff_d  = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;  // subtraction is A + ~B + 1
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        psum_d[base +: SliceW] = slice_s;
        carry_d = bus.clu_c[SliceW-1];
        if (cnt_q != LastCnt) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          sum_d   = psum_d;
          cout_d  = bus.clu_c[SliceW-1];
          ovf_d   = bus.clu_c[SliceW-2] ^ bus.clu_c[SliceW-1];
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers on falling PHI, after the carries have evaluated.
  always_ff @(negedge phi or negedge rst_) begin
    if (!rst_) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      beff_q  <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      beff_q  <= beff_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_clu_slice_sequencer.sv
// Bench for clu_slice_sequencer with a behavioural 4-bit domino lookahead unit on the slice bus.
module tb_clu_slice_sequencer;

  logic phi;
  logic phi_late;  // evaluate/precharge of the carry unit trails PHI slightly
  logic rst_;

  int nchecks = 0;
  int nfail   = 0;

  clu_slice_sequencer_if #(.Width(16)) bus ();

  clu_slice_sequencer #(.Width(16)) dut (
    .phi  (phi),
    .rst_ (rst_),
    .bus  (bus)
  );

  function automatic logic [3:0] clu_eval(input logic [3:0] p, input logic [3:0] g,
                                          input logic c0);
    logic c1, c2, c3, c4;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & c1);
    c3 = g[2] | (p[2] & c2);
    c4 = g[3] | (p[3] & c3);
    return {c4, c3, c2, c1};
  endfunction

  // Carries are valid while evaluating and precharge to 0 while PHI is low.
  assign bus.clu_c = phi_late ? clu_eval(bus.clu_p, bus.clu_g, bus.clu_c0) : 4'b0000;

  initial begin
    phi      = 1'b1;
    phi_late = 1'b1;
    forever begin
      #1 phi_late = phi;
      #4 phi = ~phi;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation, scramble inputs afterwards, wait (bounded) for DONE.
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                        output int lat, output int bcnt);
    @(posedge phi);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    bus.sub   = sv;
    @(posedge phi);
    bus.start = 1'b0;
    bus.a     = ~av;
    bus.b     = ~bv;
    bus.sub   = ~sv;
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bcnt++;
      @(posedge phi);
      lat++;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, bcnt, n;
    logic seen_done;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

    rst_      = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sub   = 1'b0;
    #12;
    check("rst_busy",   32'(bus.busy),   0);
    check("rst_done",   32'(bus.done),   0);
    check("rst_sum",    32'(bus.sum),    0);
    check("rst_cout",   32'(bus.cout),   0);
    check("rst_ovf",    32'(bus.ovf),    0);
    check("rst_clu_p",  32'(bus.clu_p),  0);
    check("rst_clu_g",  32'(bus.clu_g),  0);
    check("rst_clu_c0", 32'(bus.clu_c0), 0);
    @(posedge phi);
    #2 rst_ = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat, bcnt);
      check($sformatf("v%0d_done", i),    32'(bus.done), 1);
      check($sformatf("v%0d_latency", i), 32'(lat),      4);
      check($sformatf("v%0d_busy", i),    32'(bcnt),     4);
      check($sformatf("v%0d_sum", i),     32'(bus.sum),  32'(vecs[i].sum));
      check($sformatf("v%0d_cout", i),    32'(bus.cout), 32'(vecs[i].cout));
      check($sformatf("v%0d_ovf", i),     32'(bus.ovf),  32'(vecs[i].ovf));
      @(posedge phi);
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 0);
      check($sformatf("v%0d_idle_clu", i),
            32'({bus.busy, bus.clu_p, bus.clu_g, bus.clu_c0}), 0);
      check($sformatf("v%0d_sum_held", i), 32'(bus.sum), 32'(vecs[i].sum));
    end

    // START held high: mid-run requests ignored, next op taken in the DONE cycle.
    @(posedge phi);
    bus.start = 1'b1;
    bus.a     = 16'h1111;
    bus.b     = 16'h2222;
    bus.sub   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge phi);
      if (i == 4) begin
        check("b2b_done1", 32'(bus.done), 1);
        check("b2b_sum1",  32'(bus.sum),  32'h3333);
        bus.a   = 16'h0F0F;
        bus.b   = 16'h0101;
        bus.sub = 1'b1;
      end else begin
        check($sformatf("b2b_run%0d", i), 32'({bus.busy, bus.done}), 32'h2);
        bus.a   = 16'hFFFF;
        bus.b   = 16'hFFFF;
        bus.sub = 1'b0;
      end
    end
    @(posedge phi);
    check("b2b_accept", 32'({bus.busy, bus.done}), 32'h2);
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    n = 0;
    while (!bus.done && n < 20) begin
      @(posedge phi);
      n++;
    end
    check("b2b_done2",   32'(bus.done), 1);
    check("b2b_latency", 32'(n),        4);
    check("b2b_sum2",    32'(bus.sum),  32'h0E0E);
    check("b2b_cout2",   32'(bus.cout), 1);
    check("b2b_ovf2",    32'(bus.ovf),  0);

    // Reset pulse while slice 2 is on the bus.
    @(posedge phi);
    @(posedge phi);
    bus.start = 1'b1;
    bus.a     = 16'h1234;
    bus.b     = 16'h4321;
    bus.sub   = 1'b0;
    @(posedge phi);
    bus.start = 1'b0;
    @(posedge phi);
    @(posedge phi);
    check("abort_slice2_p", 32'(bus.clu_p), 32'h1);
    check("abort_slice2_g", 32'(bus.clu_g), 32'h2);
    #2 rst_ = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_done", 32'(bus.done), 0);
    check("abort_res",  32'({bus.sum, bus.cout, bus.ovf}), 0);
    check("abort_clu",  32'({bus.clu_p, bus.clu_g, bus.clu_c0}), 0);
    @(posedge phi);
    #2 rst_ = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge phi);
      seen_done = seen_done | bus.done | bus.busy;
    end
    check("abort_no_done", 32'(seen_done), 0);
    run_op(16'h0001, 16'h0001, 1'b0, lat, bcnt);
    check("post_abort_done", 32'(bus.done), 1);
    check("post_abort_sum",  32'(bus.sum),  32'h0002);
    check("post_abort_cout", 32'(bus.cout), 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
